truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//  Sequencer for an N-input, 1-output combinational function block (e.g. the 4-input PoS unit).
//  On start it drives all 2^N input vectors in ascending order and samples the block output.
//  Captured outputs are compared against an expected minterm mask; results are held until the next run.
//  Replaces hand-written #1 stimulus lists with a self-checking, clocked sweep.
// PARAMETERS
//  N_IN      4         number of function inputs; vector bit N_IN-1 = X (MSB) ... bit 0 = Z
//  EXP_MASK  16'h7F00  expected output per vector; bit i = required output for input i (default = PoS M(0-7,15))
//  SETTLE    1         idle cycles a vector is held before it is sampled (>=1)
// PORTS
//  clk             in   1        rising-edge clock
//  rst             in   1        synchronous, active-high reset
//  start           in   1        begin a sweep; honoured only in IDLE
//  dut_out         in   1        output of the function block under sequencing
//  dut_in          out  N_IN     input vector driven to the function block
//  busy            out  1        high from the accepting edge until the last sample
//  done            out  1        one-cycle pulse when a sweep ends
//  pass            out  1        1 = every sampled vector matched EXP_MASK (valid when !busy)
//  fail_count      out  N_IN+1   number of mismatching vectors (saturates impossible: max 2^N fits)
//  first_fail_idx  out  N_IN     index of the lowest mismatching vector; 0 if none
//  captured        out  2^N_IN   sampled outputs, bit i = dut_out for vector i
// BEHAVIOUR
//  - Reset: dut_in=0, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0, captured=0, state=IDLE.
//  - FSM: IDLE -> HOLD -> SAMPLE -> (HOLD for next vector | DONE) -> IDLE.
//    IDLE:   start=1 at edge E0 -> idx=0, dut_in=0, busy=1, clear fail_count/first_fail_idx/captured/pass -> HOLD.
//    HOLD:   dut_in=idx stable for SETTLE cycles -> SAMPLE.
//    SAMPLE: captured[idx]<=dut_out; mismatch if dut_out !== EXP_MASK[idx] (X/Z count as mismatch);
//            on mismatch fail_count++, first_fail_idx<=idx if first; idx==2^N-1 -> DONE else idx++, dut_in<=idx+1 -> HOLD.
//    DONE:   done=1 one cycle, busy=0, pass=(fail_count==0) -> IDLE.
//  - Latency (SETTLE=1, N_IN=4): sample of vector i at edge E0+2(i+1); done high in the cycle after edge E0+32.
//  - start while busy or in DONE: ignored, no restart. start in the IDLE cycle after DONE: accepted (back-to-back).
//  - Results (pass, fail_count, first_fail_idx, captured) hold after DONE until the next accepted start.
//  - rst mid-sweep: next edge returns to reset values; no done pulse for the aborted sweep.
//  - idx wrap: never increments past 2^N-1; counter width N_IN+1 for terminal detect.
// CONFIGURATION
//  SWEEP_STOP_ON_FAIL_EN defined: first mismatch in SAMPLE goes directly to DONE; fail_count=1,
//    first_fail_idx=failing index, captured bits above it stay 0, dut_in holds the failing vector.
//  Not defined: all 2^N vectors are always swept; mismatches only accumulate.
// STRUCTURE
//  Package sweep_pkg: state enum {IDLE,HOLD,SAMPLE,DONE}, localparam N_VEC=2**N_IN,
//    function sweep_latency(n_in,settle) = (settle+1)*2**n_in used by the bench.
//  Sub-module tt_vec_counter: idx register, settle counter, clear/advance/terminal flags.
//  Top holds FSM, compare, result registers; function block instantiated outside, wired via dut_in/dut_out.
// TESTING
//  1 Known-good PoS block, EXP_MASK=16'h7F00, start at E0 -> done after E0+32, pass=1, fail_count=0, captured=16'h7F00.
//  2 dut_out tied 0 -> pass=0, fail_count=7, first_fail_idx=8, captured=16'h0000.
//  3 SWEEP_STOP_ON_FAIL_EN, dut_out tied 0 -> done after E0+18, fail_count=1, first_fail_idx=8, dut_in=4'b1000.
//  4 rst=1 while dut_in=5 -> next cycle busy=0, dut_in=0, captured=0, no done pulse; fresh start gives case-1 result.
//  5 start pulsed at E0+6 mid-sweep -> ignored, done still after E0+32; start held through DONE -> second sweep starts next IDLE edge.
//  6 dut_out=1'bx at vector 3 only -> fail_count=1, first_fail_idx=3, pass=0.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// sweep_pkg: shared FSM state type and sweep timing helpers for truth_table_sweeper.
package sweep_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;
    localparam int N_IN_DEF = 4;
    localparam int N_VEC = 2**N_IN_DEF;
    function automatic int sweep_latency(input int n_in, input int settle);
        return (settle + 1) * (2**n_in);
    endfunction
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: sweep control, function-block stimulus/response and result bus.
interface truth_table_sweeper_if #(parameter int N_IN = 4);
    logic start, dut_out, busy, done, pass;
    logic [N_IN-1:0] dut_in, first_fail_idx;
    logic [N_IN:0] fail_count;
    logic [2**N_IN-1:0] captured;
    modport master(output start, dut_out,
                   input dut_in, busy, done, pass, fail_count, first_fail_idx, captured);
    modport slave(input start, dut_out,
                  output dut_in, busy, done, pass, fail_count, first_fail_idx, captured);
endinterface

// File: rtl/truth_table_sweeper_counter.sv
// tt_vec_counter: vector index plus settle counter; one extra index bit gives terminal detect.
module tt_vec_counter #(
    parameter int N_IN = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            advance,
    input  logic            hold,
    output logic [N_IN-1:0] idx,
    output logic            settle_done,
    output logic            last
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(2**N_IN - 1);
    logic [N_IN:0] cnt;
    logic [SW-1:0] scnt;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            scnt <= '0;
        end else if (advance) begin
            cnt  <= cnt + 1'b1;
            scnt <= '0;
        end else if (hold && !settle_done) begin
            scnt <= scnt + 1'b1;
        end
    end
    assign idx = cnt[N_IN-1:0];
    assign settle_done = scnt == SW'(SETTLE - 1);
    assign last = cnt == LAST_IDX;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: clocked exhaustive sweep of an N-input function block against EXP_MASK.
// Define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module truth_table_sweeper import sweep_pkg::*; #(
    parameter int N_IN = 4,
    parameter logic [2**N_IN-1:0] EXP_MASK = 16'h7F00,
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic rst,
    truth_table_sweeper_if.slave sw
);
    state_t state;
    logic [N_IN-1:0] idx;
    logic settle_done, last, clear, advance, mis, stop;
    assign clear = state == IDLE && sw.start;
    // X/Z on the block output must count as a mismatch, hence the case inequality
    assign mis = sw.dut_out !== EXP_MASK[idx];
`ifdef SWEEP_STOP_ON_FAIL_EN
    assign stop = last || mis;
`else
    assign stop = last;
`endif
    assign advance = state == SAMPLE && !stop;
    assign sw.dut_in = idx;
    tt_vec_counter #(.N_IN(N_IN), .SETTLE(SETTLE)) u_cnt (
        .clk(clk), .rst(rst), .clear(clear), .advance(advance), .hold(state == HOLD),
        .idx(idx), .settle_done(settle_done), .last(last)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            sw.busy           <= 1'b0;
            sw.done           <= 1'b0;
            sw.pass           <= 1'b0;
            sw.fail_count     <= '0;
            sw.first_fail_idx <= '0;
            sw.captured       <= '0;
        end else begin
            case (state)
                IDLE: if (sw.start) begin
                    state             <= HOLD;
                    sw.busy           <= 1'b1;
                    sw.pass           <= 1'b0;
                    sw.fail_count     <= '0;
                    sw.first_fail_idx <= '0;
                    sw.captured       <= '0;
                end
                HOLD: state <= settle_done ? SAMPLE : HOLD;
                SAMPLE: begin
                    sw.captured[idx] <= sw.dut_out;
                    if (mis) begin
                        sw.fail_count <= sw.fail_count + 1'b1;
                        if (sw.fail_count == '0) sw.first_fail_idx <= idx;
                    end
                    if (stop) begin
                        state   <= DONE;
                        sw.busy <= 1'b0;
                        sw.done <= 1'b1;
                        sw.pass <= !mis && sw.fail_count == '0;
                    end else begin
                        state <= HOLD;
                    end
                end
                DONE: begin
                    sw.done <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
